// File: rtl/dmem_sram_bridge_pkg.sv
// Shared types and bus encodings for the memory-stage to split-transaction bus bridge.
package dmem_sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } bridge_state_t;

  localparam logic [1:0] BUS_SZ_BYTE = 2'd0;
  localparam logic [1:0] BUS_SZ_HALF = 2'd1;
  localparam logic [1:0] BUS_SZ_WORD = 2'd2;

endpackage

// File: rtl/dmem_sram_bridge_wen_to_size.sv
// Byte-enable decode: a nonzero mask is a write; the mask shape selects the bus transfer size.
module wen_to_size
  import dmem_sram_bridge_pkg::*;
(
  input  logic [3:0] i_wen,
  output logic       o_wr,
  output logic [1:0] o_size
);

  always_comb begin
    o_wr   = |i_wen;
    o_size = BUS_SZ_WORD;
    case (i_wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: o_size = BUS_SZ_BYTE;
      4'b0011, 4'b1100:                   o_size = BUS_SZ_HALF;
      // Reads and irregular masks go out as full words.
      default:                            o_size = BUS_SZ_WORD;
    endcase
  end

endmodule

// File: rtl/dmem_sram_bridge.sv
// Turns the memory stage's single-cycle SRAM port into a req/addr_ok + data_ok bus,
// stalling while an access is outstanding and absorbing flushed accesses.
module dmem_sram_bridge
  import dmem_sram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [3:0]        mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              kill,
  input  logic              pipe_hold,
  output logic              stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  bridge_state_t     r_state, w_state_nxt;
  logic              r_drop, w_drop_nxt;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_fire, w_latch, w_cap;
  logic              w_in_wr;
  logic [1:0]        w_in_size;
  logic [ADDR_W-1:0] w_in_addr;

  wen_to_size u_wen_to_size (
    .i_wen  (mem_wen),
    .o_wr   (w_in_wr),
    .o_size (w_in_size)
  );

  // Reads are always word transfers, so the sub-word offset is dropped.
  assign w_in_addr = w_in_wr ? mem_addr : {mem_addr[ADDR_W-1:2], 2'b00};
  assign w_fire    = mem_en & ~kill;

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_latch     = 1'b0;
    w_cap       = 1'b0;
    data_req    = 1'b0;
    stall       = 1'b0;
    data_wr     = r_wr;
    data_size   = r_size;
    data_addr   = r_addr;
    data_wdata  = r_wdata;
    mem_rdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_fire) begin
          data_req    = 1'b1;
          stall       = 1'b1;
          data_wr     = w_in_wr;
          data_size   = w_in_size;
          data_addr   = w_in_addr;
          data_wdata  = mem_wdata;
          w_latch     = 1'b1;
          w_state_nxt = data_addr_ok ? DATA : ADDR;
        end
      end
      ADDR: begin
        data_req = 1'b1;
        stall    = 1'b1;
        if (kill) w_drop_nxt = 1'b1;
        if (data_addr_ok) w_state_nxt = DATA;
      end
      DATA: begin
        stall = 1'b1;
        if (kill) w_drop_nxt = 1'b1;
        if (data_data_ok) begin
          w_cap = 1'b1;
          // A flushed access still consumes its response but never reaches DONE.
          if (r_drop || kill) begin
            w_state_nxt = IDLE;
            w_drop_nxt  = 1'b0;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        mem_rdata = r_rdata;
        if (!pipe_hold || kill) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst) begin
      data_req  = 1'b0;
      stall     = 1'b0;
      mem_rdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_drop  <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      if (w_latch) begin
        r_wr    <= w_in_wr;
        r_size  <= w_in_size;
        r_addr  <= w_in_addr;
        r_wdata <= mem_wdata;
      end
      if (w_cap) r_rdata <= r_wr ? '0 : data_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge: reads, sized stores, hold in DONE, kills and reset.
module tb_dmem_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        kill;
  logic        pipe_hold;
  logic        stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dmem_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_en       (mem_en),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .kill         (kill),
    .pipe_hold    (pipe_hold),
    .stall        (stall),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks happen 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // One access accepted immediately, response on the next cycle, pipeline free.
  task automatic access(input string tag, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] resp,
                        input logic exp_wr, input logic [1:0] exp_size,
                        input logic [31:0] exp_addr, input logic [31:0] exp_rdata);
    mem_en = 1'b1; mem_wen = wen; mem_addr = addr; mem_wdata = wdata; data_addr_ok = 1'b1;
    settle();
    chk({tag, "_req"},   data_req,  1'b1);
    chk({tag, "_wr"},    data_wr,   exp_wr);
    chk({tag, "_size"},  data_size, exp_size);
    chk({tag, "_addr"},  data_addr, exp_addr);
    chk({tag, "_stall0"}, stall,    1'b1);
    if (exp_wr) chk({tag, "_wdata"}, data_wdata, wdata);
    tick();
    mem_en = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = resp;
    settle();
    chk({tag, "_stall1"}, stall,    1'b1);
    chk({tag, "_noreq1"}, data_req, 1'b0);
    tick();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    settle();
    chk({tag, "_stall2"}, stall,     1'b0);
    chk({tag, "_rdata"},  mem_rdata, exp_rdata);
    tick();
    settle();
    chk({tag, "_idle_rdata"}, mem_rdata, 32'h0);
  endtask

  initial begin
    rst = 1'b1; mem_en = 1'b1; mem_wen = 4'h0; mem_addr = 32'h100; mem_wdata = 32'h0;
    kill = 1'b0; pipe_hold = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    tick();
    tick();
    settle();
    chk("rst_req",   data_req,  1'b0);
    chk("rst_stall", stall,     1'b0);
    chk("rst_rdata", mem_rdata, 32'h0);
    rst = 1'b0; mem_en = 1'b0;
    tick();

    // Minimum-latency read with unaligned address.
    access("rd", 4'b0000, 32'h0000_1006, 32'h0, 32'hDEAD_BEEF,
           1'b0, 2'd2, 32'h0000_1004, 32'hDEAD_BEEF);

    // Byte store with addr_ok delayed three cycles; bus fields must hold.
    mem_en = 1'b1; mem_wen = 4'b0100; mem_addr = 32'h0000_2002; mem_wdata = 32'h00AB_0000;
    data_addr_ok = 1'b0;
    settle();
    chk("sb_req0",  data_req,  1'b1);
    chk("sb_wr0",   data_wr,   1'b1);
    chk("sb_size0", data_size, 2'd0);
    chk("sb_addr0", data_addr, 32'h0000_2002);
    for (int i = 1; i < 4; i++) begin
      tick();
      mem_en = 1'b0; mem_wen = 4'b1111; mem_addr = 32'hFFFF_FFF0 + i; mem_wdata = 32'h5555_5555;
      data_addr_ok = (i == 3);
      settle();
      chk($sformatf("sb_req%0d", i),   data_req,   1'b1);
      chk($sformatf("sb_size%0d", i),  data_size,  2'd0);
      chk($sformatf("sb_addr%0d", i),  data_addr,  32'h0000_2002);
      chk($sformatf("sb_wdata%0d", i), data_wdata, 32'h00AB_0000);
      chk($sformatf("sb_stall%0d", i), stall,      1'b1);
    end
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    settle();
    chk("sb_data_noreq", data_req, 1'b0);
    tick();
    data_data_ok = 1'b0;
    settle();
    chk("sb_done_stall", stall,     1'b0);
    chk("sb_done_rdata", mem_rdata, 32'h0);
    tick();

    // Store size decode across mask shapes.
    access("sh",   4'b1100, 32'h0000_3002, 32'hBEEF_0000, 32'hFFFF_FFFF, 1'b1, 2'd1, 32'h0000_3002, 32'h0);
    access("sh_lo", 4'b0011, 32'h0000_3010, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 2'd1, 32'h0000_3010, 32'h0);
    access("sw",   4'b1111, 32'h0000_3004, 32'hCAFE_BABE, 32'hFFFF_FFFF, 1'b1, 2'd2, 32'h0000_3004, 32'h0);
    access("sb1",  4'b0001, 32'h0000_3021, 32'h0000_0077, 32'h0, 1'b1, 2'd0, 32'h0000_3021, 32'h0);
    access("sb8",  4'b1000, 32'h0000_3023, 32'h9900_0000, 32'h0, 1'b1, 2'd0, 32'h0000_3023, 32'h0);
    access("sodd", 4'b0110, 32'h0000_3031, 32'h00AA_BB00, 32'h0, 1'b1, 2'd2, 32'h0000_3031, 32'h0);

    // Read completes while pipe_hold is high for two cycles.
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h0000_4000; data_addr_ok = 1'b1;
    tick();
    mem_en = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    pipe_hold = 1'b1;
    tick();
    data_data_ok = 1'b0; data_rdata = 32'h0; mem_en = 1'b1; mem_addr = 32'h0000_4444;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("hold_rdata%0d", i), mem_rdata, 32'hCAFE_F00D);
      chk($sformatf("hold_noreq%0d", i), data_req,  1'b0);
      chk($sformatf("hold_stall%0d", i), stall,     1'b0);
      tick();
    end
    pipe_hold = 1'b0; mem_en = 1'b0;
    settle();
    chk("hold_last_rdata", mem_rdata, 32'hCAFE_F00D);
    tick();
    settle();
    chk("hold_idle_rdata", mem_rdata, 32'h0);

    // Kill while in DATA: response consumed, no DONE, back to IDLE.
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h0000_5000; data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; kill = 1'b1;
    settle();
    chk("kd_stall0", stall,    1'b1);
    chk("kd_noreq0", data_req, 1'b0);
    tick();
    kill = 1'b0; mem_addr = 32'hBAD0_BAD0;
    settle();
    chk("kd_stall1", stall,    1'b1);
    chk("kd_noreq1", data_req, 1'b0);
    tick();
    mem_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
    settle();
    chk("kd_stall2", stall, 1'b1);
    tick();
    data_data_ok = 1'b0;
    settle();
    chk("kd_idle_stall", stall,     1'b0);
    chk("kd_idle_rdata", mem_rdata, 32'h0);
    chk("kd_idle_req",   data_req,  1'b0);
    access("kd_next", 4'b0000, 32'h0000_6008, 32'h0, 32'h600D_600D,
           1'b0, 2'd2, 32'h0000_6008, 32'h600D_600D);

    // Kill while in ADDR: request held until accepted, then response dropped.
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h0000_8000; data_addr_ok = 1'b0;
    tick();
    kill = 1'b1; mem_en = 1'b0; mem_addr = 32'h0;
    settle();
    chk("ka_req0",  data_req,  1'b1);
    chk("ka_addr0", data_addr, 32'h0000_8000);
    tick();
    kill = 1'b0; data_addr_ok = 1'b1;
    settle();
    chk("ka_req1",   data_req, 1'b1);
    chk("ka_stall1", stall,    1'b1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h8888_8888;
    tick();
    data_data_ok = 1'b0;
    settle();
    chk("ka_idle_stall", stall,     1'b0);
    chk("ka_idle_rdata", mem_rdata, 32'h0);

    // Kill with mem_en in IDLE issues nothing.
    mem_en = 1'b1; kill = 1'b1; mem_addr = 32'h0000_9000;
    settle();
    chk("ki_req",   data_req, 1'b0);
    chk("ki_stall", stall,    1'b0);
    tick();
    kill = 1'b0; mem_en = 1'b0;
    settle();
    chk("ki_after_req", data_req, 1'b0);

    // Reset while in ADDR.
    mem_en = 1'b1; mem_wen = 4'b1111; mem_addr = 32'h0000_7000; mem_wdata = 32'h7777_7777;
    tick();
    mem_en = 1'b0;
    settle();
    chk("ra_req_addr", data_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("ra_req",   data_req, 1'b0);
    chk("ra_stall", stall,    1'b0);
    tick();
    settle();
    chk("ra_idle_req", data_req, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
